// File: rtl/sprinkler_sequencer.sv
// Zone sequencer for the 3-to-8 sprinkler valve decoder.
// Opens each requested zone in ascending order for a fixed dwell, with all-off gaps between zones.
module sprinkler_sequencer #(
  parameter int unsigned DWELL_CYCLES = 8,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] zone_req,
  output logic       valve_en,
  output logic [2:0] valve_sel,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_RUN,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       mask_q, mask_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valve_en_q, busy_q, done_q;
  logic [2:0]       low_idx;

  // Index of the lowest pending zone (descending scan leaves the lowest hit)
  always_comb begin
    low_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (zone_req != 8'd0) begin
            mask_d  = zone_req;
            state_d = S_SEEK;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SEEK: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (mask_q != 8'd0) begin
          sel_d   = low_idx;
          mask_d  = mask_q & (mask_q - 8'd1);
          cnt_d   = DWELL_LOAD;
          state_d = S_RUN;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (mask_q != 8'd0) begin
          if (GAP_CYCLES > 0) begin
            cnt_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            state_d = S_SEEK;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          state_d = S_SEEK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        mask_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output flops track the next state so they line up with state_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      valve_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      valve_en_q <= (state_d == S_RUN);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign valve_en  = valve_en_q;
  assign valve_sel = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sprinkler_sequencer.sv
// Directed bench for sprinkler_sequencer: instance A (dwell 4, gap 2), instance B (dwell 1, gap 0).
module tb_sprinkler_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, stop_a, start_b, stop_b;
  logic [7:0] req_a, req_b;
  logic       en_a, busy_a, done_a, en_b, busy_b, done_b;
  logic [2:0] sel_a, sel_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprinkler_sequencer #(.DWELL_CYCLES(4), .GAP_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stop(stop_a), .zone_req(req_a),
    .valve_en(en_a), .valve_sel(sel_a), .busy(busy_a), .done(done_a)
  );

  sprinkler_sequencer #(.DWELL_CYCLES(1), .GAP_CYCLES(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .zone_req(req_b),
    .valve_en(en_b), .valve_sel(sel_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic [7:0] req;
    logic       en;
    logic [2:0] sel;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int en_cnt, done_cnt, done_at, seg, overlap;
    int segs[$];

    reset = 1'b1;
    start_a = 0; stop_a = 0; req_a = 0;
    start_b = 0; stop_b = 0; req_b = 0;

    // Ignored start / zone_req changes during a run with zones 0 and 7
    vecs[0]  = '{1, 0, 8'h81, 0, 0, 1, 0};
    vecs[1]  = '{1, 0, 8'h7E, 1, 0, 1, 0};
    vecs[2]  = '{0, 0, 8'h7E, 1, 0, 1, 0};
    vecs[3]  = '{0, 0, 8'h7E, 1, 0, 1, 0};
    vecs[4]  = '{0, 0, 8'h7E, 1, 0, 1, 0};
    vecs[5]  = '{0, 0, 8'h7E, 0, 0, 1, 0};
    vecs[6]  = '{1, 0, 8'h7E, 0, 0, 1, 0};
    vecs[7]  = '{0, 0, 8'h7E, 0, 0, 1, 0};
    vecs[8]  = '{0, 0, 8'h7E, 1, 7, 1, 0};
    vecs[9]  = '{0, 0, 8'h7E, 1, 7, 1, 0};
    vecs[10] = '{1, 0, 8'h7E, 1, 7, 1, 0};
    vecs[11] = '{0, 0, 8'h7E, 1, 7, 1, 0};
    vecs[12] = '{0, 0, 8'h7E, 0, 7, 1, 1};
    vecs[13] = '{0, 1, 8'h7E, 0, 7, 0, 0};

    step();
    chk("reset_en", int'(en_a), 0);
    chk("reset_sel", int'(sel_a), 0);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      start_a = vecs[i].start;
      stop_a  = vecs[i].stop;
      req_a   = vecs[i].req;
      step();
      chk($sformatf("vec%0d_en", i), int'(en_a), int'(vecs[i].en));
      chk($sformatf("vec%0d_sel", i), int'(sel_a), int'(vecs[i].sel));
      chk($sformatf("vec%0d_busy", i), int'(busy_a), int'(vecs[i].busy));
      chk($sformatf("vec%0d_done", i), int'(done_a), int'(vecs[i].done));
    end
    start_a = 0; stop_a = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("no_second_run", int'(busy_a), 0);
    end

    // Basic sequence: zones 2,5,7; done 1+3*4+2*3 = 19 cycles after start edge
    req_a = 8'b1010_0100; start_a = 1;
    step();
    start_a = 0; req_a = 0;
    chk("basic_seek_busy", int'(busy_a), 1);
    chk("basic_seek_en", int'(en_a), 0);
    en_cnt = 0; done_cnt = 0; done_at = -1; overlap = 0;
    for (int k = 1; k <= 30; k++) begin
      logic prev_en;
      logic [2:0] prev_sel;
      prev_en = en_a; prev_sel = sel_a;
      step();
      if (en_a) en_cnt++;
      if (en_a && !prev_en) segs.push_back(int'(sel_a));
      if (en_a && prev_en && sel_a != prev_sel) overlap++;
      if (done_a) begin
        done_cnt++;
        done_at = k;
      end
    end
    chk("basic_en_cycles", en_cnt, 12);
    chk("basic_done_count", done_cnt, 1);
    chk("basic_done_at", done_at, 19);
    chk("basic_overlap", overlap, 0);
    chk("basic_segments", segs.size(), 3);
    if (segs.size() == 3) begin
      chk("basic_zone0", segs[0], 2);
      chk("basic_zone1", segs[1], 5);
      chk("basic_zone2", segs[2], 7);
    end

    // Empty request
    req_a = 8'h00; start_a = 1;
    step();
    start_a = 0;
    chk("empty_done", int'(done_a), 1);
    chk("empty_busy", int'(busy_a), 1);
    chk("empty_en", int'(en_a), 0);
    step();
    chk("empty_idle_busy", int'(busy_a), 0);
    chk("empty_idle_done", int'(done_a), 0);

    // Abort during the gap after zone 1
    req_a = 8'hFF; start_a = 1;
    step();
    start_a = 0;
    for (int k = 0; k < 12; k++) step();
    chk("abort_in_gap_en", int'(en_a), 0);
    chk("abort_in_gap_sel", int'(sel_a), 1);
    chk("abort_in_gap_busy", int'(busy_a), 1);
    stop_a = 1;
    step();
    stop_a = 0;
    chk("abort_done", int'(done_a), 1);
    chk("abort_en", int'(en_a), 0);
    step();
    chk("abort_idle_busy", int'(busy_a), 0);
    chk("abort_idle_done", int'(done_a), 0);
    en_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (en_a) en_cnt++;
    end
    chk("abort_no_more_zones", en_cnt, 0);

    // Asynchronous reset during zone 3 RUN
    req_a = 8'hFF; start_a = 1;
    step();
    start_a = 0;
    for (int k = 0; k < 23; k++) step();
    chk("pre_reset_en", int'(en_a), 1);
    chk("pre_reset_sel", int'(sel_a), 3);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_en", int'(en_a), 0);
    chk("async_reset_busy", int'(busy_a), 0);
    chk("async_reset_sel", int'(sel_a), 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_reset_idle", int'(busy_a), 0);
    end

    // Zero gap, dwell 1: 1-on/1-off through zones 0..7, done 16 cycles after start edge
    req_b = 8'hFF; start_b = 1;
    step();
    start_b = 0;
    chk("zg_seek_busy", int'(busy_b), 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 16) begin
        chk($sformatf("zg_en_%0d", k), int'(en_b), k % 2);
        if (k % 2 == 1) chk($sformatf("zg_sel_%0d", k), int'(sel_b), (k - 1) / 2);
        chk($sformatf("zg_done_%0d", k), int'(done_b), 0);
      end else begin
        chk("zg_done_at16", int'(done_b), 1);
        chk("zg_done_en", int'(en_b), 0);
      end
    end
    step();
    chk("zg_idle", int'(busy_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
